// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word bus, RAM handshake state, memory arbiter state.
// No logic, no latency.
// Pure type definitions; no flow control.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Status reported by the unified RAM every cycle.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Which cache currently owns the RAM port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISERV = 2'd1,
    DSERV = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of dcache completions taken while an icache fetch waits.
// Registered count; at_limit is combinational and includes this cycle's increment.
// No backpressure; inc/clr are sampled every cycle, clr has priority.
//
// Ports:
//   CLK, nRST   clock, async active-low reset
//   inc         a dcache word completed while iREN is high
//   clr         icache is being granted, or no icache request is pending
//   at_limit    the limit is reached now or is reached by this cycle's increment
module arb_starve_counter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic CLK,
  input  logic nRST,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [CNT_W-1:0] LIM    = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIM_M1 = CNT_W'(STARVE_LIMIT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != LIM)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Look ahead by the pending increment so the completion that reaches the
  // limit already hands the next grant to the icache (exactly LIMIT dcache
  // words, not LIMIT+1).
  assign at_limit = (r_cnt == LIM) || (inc && (r_cnt == LIM_M1));

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single-ported unified RAM between icache misses and dcache fills/writebacks.
// First RAM enable one cycle after request; RAM outputs combinational from registered grant.
// Stalls the granted cache via iwait/dwait until ACCESS; the other cache sees wait=1, load=0.
//
// Ports:
//   CLK, nRST                          clock, async active-low reset
//   iREN, iaddr / iload, iwait         icache request and response
//   dREN, dWEN, dburst, daddr, dstore  dcache request (dburst keeps the grant)
//   dload, dwait                       dcache response
//   ramREN, ramWEN, ramaddr, ramstore  RAM command
//   ramload, ramstate                  RAM response
module cache_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output word_t     iload,
  output logic      iwait,
  input  logic      dREN,
  input  logic      dWEN,
  input  logic      dburst,
  input  word_t     daddr,
  input  word_t     dstore,
  output word_t     dload,
  output logic      dwait,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  arb_state_t r_state;
  arb_state_t w_next_state;
  arb_state_t w_arb;
  logic       w_dreq;
  logic       w_inc;
  logic       w_clr;
  logic       w_at_limit;
  logic       w_starved;

  assign w_dreq    = dREN | dWEN;
  assign w_inc     = (r_state == DSERV) && (ramstate == ACCESS) && iREN;
  assign w_clr     = !iREN || (w_next_state == ISERV);
  assign w_starved = iREN && w_at_limit;

  arb_starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_W       (CNT_W)
  ) u_starve (
    .CLK     (CLK),
    .nRST    (nRST),
    .inc     (w_inc),
    .clr     (w_clr),
    .at_limit(w_at_limit)
  );

  // Fresh arbitration decision, used from IDLE and at the end of every grant.
  always_comb begin
    if (w_starved)   w_arb = ISERV;
    else if (w_dreq) w_arb = DSERV;
    else if (iREN)   w_arb = ISERV;
    else             w_arb = IDLE;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    iwait        = 1'b1;
    dwait        = 1'b1;
    iload        = '0;
    dload        = '0;
    unique case (r_state)
      IDLE: begin
        w_next_state = w_arb;
      end
      ISERV: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        // A completing word counts even if the cache drops iREN in reaction
        // to iwait in the same cycle; otherwise a dropped request abandons.
        if (ramstate == ACCESS) begin
          iwait        = 1'b0;
          iload        = ramload;
          w_next_state = w_arb;
        end else if (!iREN) begin
          w_next_state = w_arb;
        end
      end
      DSERV: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (ramstate == ACCESS) begin
          dwait        = 1'b0;
          dload        = ramload;
          // A starved icache breaks an ongoing burst at the word boundary.
          w_next_state = (dburst && !w_starved) ? DSERV : w_arb;
        end else if (!w_dreq) begin
          w_next_state = w_arb;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single-ported unified RAM between the instruction-cache miss path and the data-cache fill/writeback path.
- Accepts word requests from both caches, grants one at a time, drives the RAM, and returns data and wait to the granted cache only.
- Data cache has default priority; a bounded starvation counter guarantees instruction-fetch progress.
- Dcache block transfers (dburst) hold the grant across consecutive words.

Parameters:
- STARVE_LIMIT, 4, consecutive dcache completions allowed while iREN is pending before icache is forced to win the next arbitration (range 1..15).
- CNT_W, 4, width of the starvation counter.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- iREN  in  1  icache read request
- iaddr  in  32  icache word address
- iload  out  32  read data to icache
- iwait  out  1  low for exactly the completing cycle of an icache access
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- dburst  in  1  dcache holds grant after the current word completes
- daddr  in  32  dcache word address
- dstore  in  32  dcache write data
- dload  out  32  read data to dcache
- dwait  out  1  low for exactly the completing cycle of a dcache access
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  ramstate_t: FREE=0, BUSY=1, ACCESS=2, ERROR=3

Behaviour:
- Reset values:
  - state=IDLE, starve_cnt=0.
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - iwait=1, dwait=1, iload=0, dload=0.
- State is registered; RAM-side outputs are combinational from state and the granted requester's inputs.
- States: IDLE, ISERV, DSERV.
- IDLE:
  - RAM enables are 0.
  - Arbitration, with the next state taking effect on the next edge:
    - dreq = dREN|dWEN.
    - If iREN and starve_cnt==STARVE_LIMIT, go to ISERV.
    - Else if dreq, go to DSERV.
    - Else if iREN, go to ISERV.
    - Else stay in IDLE.
  - Minimum latency from request to first RAM enable is 1 cycle.
- ISERV:
  - ramREN=iREN, ramaddr=iaddr.
  - When ramstate==ACCESS: iwait=0 and iload=ramload in that cycle, then re-arbitrate as in IDLE for the next state (back-to-back grants allowed, no bubble).
- DSERV:
  - ramWEN=dWEN.
  - ramREN=dREN&~dWEN; write takes precedence when both are asserted.
  - ramaddr=daddr, ramstore=dstore.
  - When ramstate==ACCESS: dwait=0 and dload=ramload.
  - If dburst=1, stay in DSERV. Otherwise re-arbitrate.
- The non-granted cache always sees wait=1 and load=0.
- BUSY and FREE while serving: hold state and wait=1.
- ERROR: hold state and wait=1. The RAM retries; the arbiter keeps the enables asserted.
- Withdrawal: if the granted requester drops its enable before ACCESS, deassert the RAM enables that cycle and re-arbitrate for the next state.
- Starvation counter:
  - Increments on each dcache ACCESS completion while iREN=1.
  - Saturates at STARVE_LIMIT.
  - Clears on entry to ISERV and whenever iREN=0.
  - At STARVE_LIMIT, a dburst hold is overridden after the current word completes: go to ISERV.
- Reset asserted mid-transaction: outputs return to reset values immediately (asynchronous). The partial access is abandoned; the cache re-requests.
- A cycle with iREN and dreq simultaneous, counter below limit: dcache wins.

Decomposition:
- cpu_types_pkg gains:
  - ramstate_t enum (FREE, BUSY, ACCESS, ERROR).
  - arb_state_t enum (IDLE, ISERV, DSERV).
  - Reuses word_t for all 32-bit buses.
- One sub-module, arb_starve_counter:
  - Inputs: inc, clr.
  - Output: at_limit.
  - Parameter: STARVE_LIMIT.
  - Saturating counter.
- Arbitration and mux logic stay in the top.

Test Plan:
- Lone icache read, iaddr=0x40, RAM returns ACCESS after 2 BUSY cycles with ramload=0x2402000A:
  - ramREN=1, ramaddr=0x40 from cycle 1.
  - iwait low one cycle with iload=0x2402000A.
  - Back to IDLE.
- Simultaneous iREN and dREN at cycle 0:
  - DSERV first; dcache completes.
  - ISERV on the next cycle; iwait stays 1 until then.
- dcache burst write, dburst=1 for 2 words (0x80=0xDEAD, 0x84=0xBEEF) with iREN pending:
  - ramWEN held for both words, no icache grant between them.
  - ISERV follows.
- Starvation with STARVE_LIMIT=4: continuous dREN, dburst=0, and iREN held:
  - Exactly 4 dcache completions, then the icache is granted.
  - Counter returns to 0.
- dREN and dWEN both asserted, daddr=0x100, dstore=0x55:
  - ramWEN=1, ramREN=0, ramstore=0x55.
- ERROR for 3 cycles then ACCESS during ISERV:
  - Enables stay asserted and iwait=1 throughout, then a single completion.
- nRST pulsed during DSERV with ramstate=BUSY:
  - All outputs take reset values immediately.
  - After release, a pending iREN is granted on the first edge.
